multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch,
//  decode, execute, memory and writeback. Drives the mux selects, write enables and the 2-bit
//  OpALU code consumed by the ALU control decoder. Supports lw, sw, R-type, beq, addi and j.
//  Memory accesses use a ready handshake with a timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  cycles a memory state waits for mem_ready before aborting (1..255)
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst        in   1  synchronous reset, active-high
//  opcode     in   6  instr[31:26] from the instruction register (valid from DECODE onward)
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completed the current read/write this cycle
//  PCWrite    out  1  unconditional PC load
//  PCWriteCond out 1  PC load qualified by zero (beq)
//  IorD       out  1  memory address: 0=PC, 1=ALUOut
//  MemRead    out  1  memory read request
//  MemWrite   out  1  memory write request
//  IRWrite    out  1  instruction register load
//  MemtoReg   out  1  register write data: 0=ALUOut, 1=MDR
//  RegDst     out  1  destination register: 0=rt, 1=rd
//  RegWrite   out  1  register file write enable
//  ALUSrcA    out  1  ALU A input: 0=PC, 1=rs
//  ALUSrcB    out  2  ALU B input: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
//  OpALU      out  2  to the ALU control decoder: 00 add, 01 sub, 10 funct-decoded
//  PCSrc      out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op out  1  1-cycle pulse: DECODE saw an unsupported opcode
//  mem_err    out  1  1-cycle pulse: memory timeout
// BEHAVIOUR
//  Outputs
//   - Moore outputs, decoded from the state register only. Signals not listed for a state are 0.
//   - While rst=1, every output is forced to 0 and state<=FETCH. Reset mid-instruction discards it.
//   - Timeout counter and the pulse outputs clear on reset.
//  States (Moore outputs -> transition)
//   FETCH:  MemRead, ALUSrcB=01, OpALU=00, PCSrc=00; IRWrite=PCWrite=mem_ready.
//           -> DECODE when mem_ready.
//   DECODE: ALUSrcB=11, OpALU=00 (branch target into ALUOut). Dispatch on opcode:
//           100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH;
//           001000 -> ADDIEX; 000010 -> JUMP; any other -> FETCH with illegal_op=1.
//   MEMADR: ALUSrcA=1, ALUSrcB=10, OpALU=00 -> MEMRD for lw, MEMWR for sw.
//   MEMRD:  MemRead, IorD -> MEMWB when mem_ready.
//   MEMWB:  RegWrite, MemtoReg, RegDst=0 -> FETCH.
//   MEMWR:  MemWrite, IorD -> FETCH when mem_ready.
//   EXEC:   ALUSrcA=1, ALUSrcB=00, OpALU=10 -> ALUWB.
//   ALUWB:  RegWrite, RegDst=1, MemtoReg=0 -> FETCH.
//   BRANCH: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond, PCSrc=01 -> FETCH.
//   ADDIEX: ALUSrcA=1, ALUSrcB=10, OpALU=00 -> ADDIWB.
//   ADDIWB: RegWrite, RegDst=0, MemtoReg=0 -> FETCH.
//   JUMP:   PCWrite, PCSrc=10 -> FETCH.
//  Memory handshake and timeout
//   - The timeout counter clears on entry to FETCH, MEMRD or MEMWR.
//   - The counter increments each cycle the FSM stays in that state with mem_ready=0.
//   - mem_ready in the same cycle the count reaches MEM_TIMEOUT counts as success.
//   - When the count reaches MEM_TIMEOUT with mem_ready=0: next state is FETCH, mem_err pulses 1 cycle.
//   - No write-enable or PC update occurs on the abort cycle.
//   - The same abort applies in FETCH: the PC is not advanced and fetch restarts.
//  Latency (zero-wait memory): lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles; CPI unchanged by zero flag.
// TESTING
//  - Reset: rst=1 for 2 cycles mid-MEMRD -> all outputs 0; first post-reset cycle shows FETCH, MemRead=1.
//  - lw, mem_ready tied 1: state trace FETCH,DECODE,MEMADR,MEMRD,MEMWB.
//    RegWrite=1, MemtoReg=1 only in cycle 5.
//  - R-type (opcode 0): OpALU=10 exactly in cycle 3; RegWrite and RegDst=1 in cycle 4; sw takes 4 cycles.
//  - beq: OpALU=01, PCWriteCond=1, PCSrc=01 in cycle 3 for both zero=0 and zero=1; next cycle is FETCH.
//  - opcode 111111 -> illegal_op=1 for one cycle at DECODE exit; no RegWrite/MemWrite; back in FETCH.
//  - MEMWR with mem_ready held 0, MEM_TIMEOUT=15 -> mem_err pulses after 15 wait cycles; MemWrite drops.
//    Ready on the 15th cycle -> completes with no mem_err.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing for lw, sw, R-type, beq, addi and j, with a ready/timeout memory handshake.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] OpALU,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Abort fires on the cycle the wait count would reach MEM_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg;
    logic       illegal_op_reg, mem_err_reg;
    logic       mem_state, abort, illegal_next;

    // zero only qualifies PCWriteCond in the datapath; it never alters sequencing.
    logic unused_zero;
    assign unused_zero = zero;

    assign mem_state = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    assign abort     = mem_state && !mem_ready && (cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FETCH;
            cnt_reg        <= 8'd0;
            illegal_op_reg <= 1'b0;
            mem_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            illegal_op_reg <= illegal_next;
            mem_err_reg    <= abort;
            if (state_next != state_reg || abort)
                cnt_reg <= 8'd0;
            else if (!mem_ready)
                cnt_reg <= cnt_reg + 8'd1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        illegal_next = 1'b0;
        case (state_reg)
            FETCH: begin
                if (abort)          state_next = FETCH;
                else if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        state_next   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (abort)          state_next = FETCH;
                else if (mem_ready) state_next = MEMWB;
            end
            MEMWR: begin
                if (abort || mem_ready) state_next = FETCH;
            end
            EXEC:    state_next = ALUWB;
            ADDIEX:  state_next = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        OpALU       = 2'b00;
        PCSrc       = 2'b00;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;
        if (!rst) begin
            illegal_op = illegal_op_reg;
            mem_err    = mem_err_reg;
            case (state_reg)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE:  ALUSrcB = 2'b11;
                MEMADR, ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    OpALU   = 2'b10;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    OpALU       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'b01;
                end
                ADDIWB:  RegWrite = 1'b1;
                JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-cycle output vector checks.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, mem_err;
    logic [1:0] ALUSrcB, OpALU, PCSrc;

    int compared   = 0;
    int mismatched = 0;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .OpALU(OpALU),
        .PCSrc(PCSrc), .illegal_op(illegal_op), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //  ALUSrcA,ALUSrcB[1:0],OpALU[1:0],PCSrc[1:0],illegal_op,mem_err}
    logic [17:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSrc, illegal_op, mem_err};

    localparam logic [17:0] E_ZERO   = 18'b0;
    localparam logic [17:0] E_FETCH  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_FWAIT  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] E_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [17:0] E_MEMWR  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] E_ALUWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [17:0] E_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [17:0] E_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [17:0] E_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
    localparam logic [17:0] B_ILL    = 18'b10;
    localparam logic [17:0] B_MERR   = 18'b01;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    // Drive one cycle's inputs, then check the Moore outputs away from the rising edge.
    task automatic step(input logic r, input logic rdy, input logic [5:0] op, input logic z,
                        input logic [17:0] exp, input string tag);
        @(negedge clk);
        rst = r; mem_ready = rdy; opcode = op; zero = z;
        #1;
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
        $display("step %-14s rst=%0d rdy=%0d op=%b obs=%b", tag, r, rdy, op, obs);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = 6'b0; zero = 1'b0;
        step(1, 0, RT, 0, E_ZERO, "reset0");
        step(1, 1, RT, 0, E_ZERO, "reset1");

        // lw, zero-wait: 5 cycles
        step(0, 1, LW, 0, E_FETCH,  "lw_fetch");
        step(0, 1, LW, 0, E_DECODE, "lw_decode");
        step(0, 1, LW, 0, E_MEMADR, "lw_memadr");
        step(0, 1, LW, 0, E_MEMRD,  "lw_memrd");
        step(0, 1, LW, 0, E_MEMWB,  "lw_memwb");
        // sw: 4 cycles
        step(0, 1, SW, 0, E_FETCH,  "sw_fetch");
        step(0, 1, SW, 0, E_DECODE, "sw_decode");
        step(0, 1, SW, 0, E_MEMADR, "sw_memadr");
        step(0, 1, SW, 0, E_MEMWR,  "sw_memwr");
        // R-type
        step(0, 1, RT, 0, E_FETCH,  "r_fetch");
        step(0, 1, RT, 0, E_DECODE, "r_decode");
        step(0, 1, RT, 0, E_EXEC,   "r_exec");
        step(0, 1, RT, 0, E_ALUWB,  "r_aluwb");
        // addi
        step(0, 1, ADDI, 0, E_FETCH,  "addi_fetch");
        step(0, 1, ADDI, 0, E_DECODE, "addi_decode");
        step(0, 1, ADDI, 0, E_MEMADR, "addi_ex");
        step(0, 1, ADDI, 0, E_ADDIWB, "addi_wb");
        // beq with zero=0 then zero=1: identical sequencing
        step(0, 1, BEQ, 0, E_FETCH,  "beq0_fetch");
        step(0, 1, BEQ, 0, E_DECODE, "beq0_decode");
        step(0, 1, BEQ, 0, E_BRANCH, "beq0_branch");
        step(0, 1, BEQ, 1, E_FETCH,  "beq1_fetch");
        step(0, 1, BEQ, 1, E_DECODE, "beq1_decode");
        step(0, 1, BEQ, 1, E_BRANCH, "beq1_branch");
        // j
        step(0, 1, J, 0, E_FETCH,  "j_fetch");
        step(0, 1, J, 0, E_DECODE, "j_decode");
        step(0, 1, J, 0, E_JUMP,   "j_jump");
        // illegal opcode: pulse in the FETCH cycle that follows DECODE
        step(0, 1, BAD, 0, E_FETCH,           "ill_fetch");
        step(0, 1, BAD, 0, E_DECODE,          "ill_decode");
        step(0, 1, SW,  0, E_FETCH | B_ILL,   "ill_pulse");
        // sw with mem_ready held low: 15 wait cycles then abort
        step(0, 1, SW, 0, E_DECODE, "swto_decode");
        step(0, 1, SW, 0, E_MEMADR, "swto_memadr");
        for (int i = 0; i < 15; i++)
            step(0, 0, SW, 0, E_MEMWR, "swto_wait");
        step(0, 0, SW, 0, E_FWAIT | B_MERR, "swto_abort");
        step(0, 1, SW, 0, E_FETCH,  "swto_refetch");
        // sw with ready on the 15th cycle: completes, no mem_err
        step(0, 1, SW, 0, E_DECODE, "sw15_decode");
        step(0, 1, SW, 0, E_MEMADR, "sw15_memadr");
        for (int i = 0; i < 14; i++)
            step(0, 0, SW, 0, E_MEMWR, "sw15_wait");
        step(0, 1, SW, 0, E_MEMWR, "sw15_ready");
        step(0, 1, LW, 0, E_FETCH, "sw15_done");
        // reset in the middle of a stalled MEMRD
        step(0, 1, LW, 0, E_DECODE, "rst_decode");
        step(0, 1, LW, 0, E_MEMADR, "rst_memadr");
        step(0, 0, LW, 0, E_MEMRD,  "rst_memrd0");
        step(0, 0, LW, 0, E_MEMRD,  "rst_memrd1");
        step(1, 0, LW, 0, E_ZERO,   "rst_mid0");
        step(1, 1, LW, 0, E_ZERO,   "rst_mid1");
        // fetch timeout: PC not advanced, fetch restarts with mem_err pulse
        for (int i = 0; i < 15; i++)
            step(0, 0, J, 0, E_FWAIT, "fto_wait");
        step(0, 1, J, 0, E_FETCH | B_MERR, "fto_refetch");
        step(0, 1, J, 0, E_DECODE, "fto_decode");
        step(0, 1, J, 0, E_JUMP,   "fto_jump");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
